// File: rtl/lfsr_pkg.sv
//------------------------------------------------------------------------------
// Module  : lfsr_pkg
// Purpose : Shared constants for the 20-bit Fibonacci LFSR family
//           (X^20 + X^13 + X^9 + X^5 + 1, right shift). Holds the register
//           width, the feedback tap positions, the generator reset seed and
//           the stream-checker state encoding.
// Ports   : none (package)
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package lfsr_pkg;

  localparam int LFSR_W = 20;

  // Feedback taps: d0 = s[15] ^ s[11] ^ s[7] ^ s[0]
  localparam int TAP_A = 15;
  localparam int TAP_B = 11;
  localparam int TAP_C = 7;
  localparam int TAP_D = 0;

  localparam logic [LFSR_W-1:0] DEFAULT_SEED = 20'h99999;

  typedef logic [LFSR_W-1:0] lfsr_t;

  // Checker state encoding (value is visible on the state port)
  localparam logic [1:0] ST_SEED   = 2'd0;
  localparam logic [1:0] ST_VERIFY = 2'd1;
  localparam logic [1:0] ST_LOCKED = 2'd2;

endpackage

`default_nettype wire

// File: rtl/lfsr_stream_checker_predict.sv
//------------------------------------------------------------------------------
// Module  : lfsr_predict
// Purpose : Combinational one-step model of the 20-bit Fibonacci LFSR.
//           Given the current register contents it produces the bit the
//           generator will shift in next and the register after the advance.
// Ports   : cur       in  20  current LFSR state (cur[0] is the output bit)
//           pred_bit  out 1   feedback bit cur[15]^cur[11]^cur[7]^cur[0]
//           nxt       out 20  state after one right-shift advance
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_predict
  import lfsr_pkg::*;
(
  input  logic [LFSR_W-1:0] cur,
  output logic              pred_bit,
  output logic [LFSR_W-1:0] nxt
);

  assign pred_bit = cur[TAP_A] ^ cur[TAP_B] ^ cur[TAP_C] ^ cur[TAP_D];
  assign nxt      = {pred_bit, cur[LFSR_W-1:1]};

endmodule

`default_nettype wire

// File: rtl/lfsr_stream_checker.sv
//------------------------------------------------------------------------------
// Module  : lfsr_stream_checker
// Purpose : Self-synchronising receiver for the serial output of the 20-bit
//           Fibonacci LFSR generator. Loads 20 bits, verifies a run of
//           predictions, then flywheels the recovered state while counting
//           mispredictions and flagging returns to the generator seed.
// Ports   : clk        in  1      clock, all state on posedge
//           rst        in  1      asynchronous active-low reset
//           bit_valid  in  1      bit_in accepted on this edge
//           bit_in     in  1      serial generator bit
//           state      out 2      0=SEED 1=VERIFY 2=LOCKED
//           locked     out 1      state==LOCKED
//           lfsr_est   out 20     recovered generator state
//           pred_bit   out 1      predicted next bit (combinational)
//           bit_err    out 1      pulse: last accepted bit mispredicted
//           err_count  out ERR_W  saturating mispredict count in LOCKED
//           seed_hit   out 1      pulse: lfsr_est became SEED in LOCKED
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module lfsr_stream_checker
  import lfsr_pkg::*;
#(
  parameter logic [LFSR_W-1:0] SEED     = DEFAULT_SEED,
  parameter logic [7:0]        LOCK_CNT = 8'd8,
  parameter logic [7:0]        LOSS_CNT = 8'd4,
  parameter int                ERR_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              bit_valid,
  input  logic              bit_in,
  output logic [1:0]        state,
  output logic              locked,
  output logic [LFSR_W-1:0] lfsr_est,
  output logic              pred_bit,
  output logic              bit_err,
  output logic [ERR_W-1:0]  err_count,
  output logic              seed_hit
);

  localparam logic [4:0]       FILL_LAST = 5'(LFSR_W - 1);
  localparam logic [ERR_W-1:0] ERR_ONE   = {{(ERR_W-1){1'b0}}, 1'b1};

  logic [4:0]        fill;
  logic [7:0]        match;
  logic [7:0]        miss;
  logic [LFSR_W-1:0] fly_next;
  logic [LFSR_W-1:0] shift_in;
  logic [7:0]        match_nxt;
  logic [7:0]        miss_nxt;
  logic              bit_ok;

  lfsr_predict u_predict (
    .cur      (lfsr_est),
    .pred_bit (pred_bit),
    .nxt      (fly_next)
  );

  // While acquiring, the received bit itself is shifted in; once locked the
  // predicted bit is used instead so isolated line errors never corrupt the
  // recovered state.
  assign shift_in  = {bit_in, lfsr_est[LFSR_W-1:1]};
  assign bit_ok    = (bit_in == pred_bit);
  assign match_nxt = match + 8'd1;
  assign miss_nxt  = miss + 8'd1;
  assign locked    = (state == ST_LOCKED);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_SEED;
      lfsr_est  <= '0;
      fill      <= '0;
      match     <= '0;
      miss      <= '0;
      err_count <= '0;
      bit_err   <= 1'b0;
      seed_hit  <= 1'b0;
    end else begin
      bit_err  <= 1'b0;
      seed_hit <= 1'b0;
      if (bit_valid) begin
        case (state)
          ST_SEED: begin
            lfsr_est <= shift_in;
            if (fill == FILL_LAST) begin
              fill <= '0;
              // All-zero is the LFSR lock-up state: never leave SEED on it.
              if (shift_in != '0) begin
                state <= ST_VERIFY;
                match <= '0;
              end
            end else begin
              fill <= fill + 5'd1;
            end
          end

          ST_VERIFY: begin
            lfsr_est <= shift_in;
            if (bit_ok) begin
              match <= match_nxt;
              if (match_nxt == LOCK_CNT) begin
                state <= ST_LOCKED;
                miss  <= '0;
              end
            end else begin
              bit_err <= 1'b1;
              state   <= ST_SEED;
              fill    <= '0;
            end
          end

          ST_LOCKED: begin
            lfsr_est <= fly_next;
            if (fly_next == SEED) begin
              seed_hit <= 1'b1;
            end
            if (bit_ok) begin
              miss <= '0;
            end else begin
              bit_err <= 1'b1;
              if (err_count != '1) begin
                err_count <= err_count + ERR_ONE;
              end
              miss <= miss_nxt;
              if (miss_nxt == LOSS_CNT) begin
                state <= ST_SEED;
                fill  <= '0;
              end
            end
          end

          default: begin
            state <= ST_SEED;
            fill  <= '0;
          end
        endcase
      end
    end
  end

endmodule

`default_nettype wire
